// File: rtl/runner_pkg.sv
// runner_pkg: shared types and constants for the running-man controller.
//   state_t       controller states (also exported on the debug port)
//   LANEx_Y       man top row for each of the three lanes
//   SHAPE_*       obstacle lane shape codes (2'b01 also reads as a top gap)
//   SCREEN_W/H    screen size in pixels
package runner_pkg;

  typedef enum logic [3:0] {
    ST_FLOORS,
    ST_WAIT,
    ST_ERASE,
    ST_LOAD,
    ST_TREE,
    ST_MAN,
    ST_CHECK,
    ST_OVER,
    ST_DEAD
  } state_t;

  localparam logic [6:0] LANE0_Y = 7'd28;
  localparam logic [6:0] LANE1_Y = 7'd68;
  localparam logic [6:0] LANE2_Y = 7'd108;

  localparam logic [1:0] SHAPE_TOPGAP = 2'b00;
  localparam logic [1:0] SHAPE_BOTGAP = 2'b10;
  localparam logic [1:0] SHAPE_WALL   = 2'b11;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  function automatic logic [6:0] lane_to_y(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_to_y = LANE0_Y;
      2'd1:    lane_to_y = LANE1_Y;
      default: lane_to_y = LANE2_Y;
    endcase
  endfunction

endpackage

// File: rtl/shape_lfsr.sv
// shape_lfsr: pseudo-random obstacle shape source.
//   clk, reset_n  clock, asynchronous active-low reset
//   advance       step the LFSR by one position (one cycle pulse)
//   shape_top/mid/bot  shapes derived from the current LFSR state
// 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5. The shapes always contain
// at least one bottom-gap lane so every obstacle can be passed crouching.
module shape_lfsr
  import runner_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  output logic [1:0] shape_top,
  output logic [1:0] shape_mid,
  output logic [1:0] shape_bot
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[6:0], feedback};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end

  // Raw shapes come from the low six bits; when none of them is a bottom
  // gap, the top two bits pick which lane gets forced to one.
  always_comb begin
    shape_top = lfsr_q[1:0];
    shape_mid = lfsr_q[3:2];
    shape_bot = lfsr_q[5:4];
    if (shape_top != SHAPE_BOTGAP && shape_mid != SHAPE_BOTGAP &&
        shape_bot != SHAPE_BOTGAP) begin
      case (lfsr_q[7:6])
        2'd0:    shape_top = SHAPE_BOTGAP;
        2'd1:    shape_mid = SHAPE_BOTGAP;
        default: shape_bot = SHAPE_BOTGAP;
      endcase
    end
  end

endmodule

// File: rtl/runner_frame_ctrl.sv
// runner_frame_ctrl: frame-sequencing controller for the running-man game.
// Draws the floors once after reset, then per frame tick runs
// ERASE -> LOAD -> TREE -> MAN -> CHECK, going to OVER/DEAD on collision.
//   clk, reset_n                 clock, asynchronous active-low reset
//   key_up/down/crouch/start     debounced key levels
//   *_finish                     datapath done levels for each draw phase
//   drawing_floors..gameover     phase selects (one-hot or idle)
//   ld_x/ld_y/ld_man_style       one-cycle load strobes, high in LOAD
//   ld_shape                     one-cycle strobe on the obstacle wrap frame
//   x_in, y_in, man_style        obstacle x, man top row, 1=standing
//   top, mid, bottom             lane shapes of the current obstacle
//   plot                         VGA write enable
//   score                        obstacles passed, saturating at 255
//   dbg_state                    current controller state
// Optional build macro SPEEDUP_EN: obstacle speed rises with the score.
// All outputs are registered; game state updates on the ERASE->LOAD edge
// so that during LOAD the outputs already carry the new frame's values.
module runner_frame_ctrl
  import runner_pkg::*;
#(
  parameter int FRAME_DIV    = 833333,
  parameter int TREE_X_START = SCREEN_W - 4,
  parameter int MAN_X        = 25,
  parameter int OVER_CYCLES  = SCREEN_W * SCREEN_H
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_crouch,
  input  logic       key_start,
  input  logic       draw_floors_finish,
  input  logic       erase_finish,
  input  logic       draw_tree_finish,
  input  logic       draw_man_finish,
  output logic       drawing_floors,
  output logic       erase,
  output logic       draw_tree,
  output logic       draw_man,
  output logic       gameover,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_man_style,
  output logic       ld_shape,
  output logic [7:0] x_in,
  output logic [6:0] y_in,
  output logic       man_style,
  output logic [1:0] top,
  output logic [1:0] mid,
  output logic [1:0] bottom,
  output logic       plot,
  output logic [7:0] score,
  output state_t     dbg_state
);

  localparam int FC_W = $clog2(FRAME_DIV + 1);
  localparam int OC_W = $clog2(OVER_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OVER_CYCLES - 1);
  localparam logic [7:0]      X_START = 8'(TREE_X_START);

  state_t          state_q, state_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [OC_W-1:0] over_cnt_q, over_cnt_d;
  logic            tick_pend_q, tick_pend_d;
  logic            up_prev_q, dn_prev_q, start_prev_q;
  logic            up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
  logic [7:0]      tree_x_q, tree_x_d;
  logic [1:0]      lane_q, lane_d;
  logic [6:0]      y_in_q, y_in_d;
  logic            man_style_q, man_style_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic            drawing_floors_q, drawing_floors_d;
  logic            erase_q, erase_d, draw_tree_q, draw_tree_d;
  logic            draw_man_q, draw_man_d, gameover_q, gameover_d;
  logic            plot_q, plot_d, ld_frame_q, ld_frame_d;
  logic            ld_shape_q, ld_shape_d;

  logic       tick, consume_tick, ticks_enabled;
  logic       up_now, dn_now, start_edge;
  logic [7:0] step;
  logic       wrap, overlap, collide;
  logic [1:0] lane_shape;
  logic [1:0] lfsr_top, lfsr_mid, lfsr_bot;

  shape_lfsr u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (ld_shape_q),
    .shape_top (lfsr_top),
    .shape_mid (lfsr_mid),
    .shape_bot (lfsr_bot)
  );

`ifdef SPEEDUP_EN
  always_comb begin
    if (score_q >= 8'd16)     step = 8'd3;
    else if (score_q >= 8'd8) step = 8'd2;
    else                      step = 8'd1;
  end
`else
  assign step = 8'd1;
`endif

  assign tick          = (frame_cnt_q == FC_LAST);
  assign ticks_enabled = (state_q != ST_OVER) && (state_q != ST_DEAD);
  // A key edge in the same cycle as the LOAD update still counts.
  assign up_now        = up_pend_q | (key_up & ~up_prev_q);
  assign dn_now        = dn_pend_q | (key_down & ~dn_prev_q);
  assign start_edge    = key_start & ~start_prev_q;
  // Wrapping whenever x is below the step keeps the subtraction from underflowing.
  assign wrap          = (tree_x_q < step);
  assign overlap       = ({1'b0, tree_x_q} + 9'd1 >= 9'(MAN_X)) &&
                         ({1'b0, tree_x_q} <= 9'(MAN_X + 6));

  always_comb begin
    case (lane_q)
      2'd0:    lane_shape = top_q;
      2'd1:    lane_shape = mid_q;
      default: lane_shape = bot_q;
    endcase
  end

  // Only a crouching man in a bottom-gap lane slips under the obstacle.
  assign collide = overlap && !(lane_shape == SHAPE_BOTGAP && !man_style_q);

  always_comb begin
    state_d      = state_q;
    over_cnt_d   = over_cnt_q;
    tree_x_d     = tree_x_q;
    lane_d       = lane_q;
    man_style_d  = man_style_q;
    score_d      = score_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    up_pend_d    = up_now;
    dn_pend_d    = dn_now;
    ld_shape_d   = 1'b0;
    consume_tick = 1'b0;
    frame_cnt_d  = tick ? '0 : frame_cnt_q + 1'b1;

    case (state_q)
      ST_FLOORS: if (draw_floors_finish) state_d = ST_WAIT;
      ST_WAIT: begin
        if (tick_pend_q) begin
          state_d      = ST_ERASE;
          consume_tick = 1'b1;
        end
      end
      ST_ERASE: begin
        if (erase_finish) begin
          state_d     = ST_LOAD;
          man_style_d = ~key_crouch;
          if (wrap) begin
            tree_x_d   = X_START;
            score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            top_d      = lfsr_top;
            mid_d      = lfsr_mid;
            bot_d      = lfsr_bot;
            ld_shape_d = 1'b1;
          end else begin
            tree_x_d = tree_x_q - step;
          end
          // Opposing requests cancel; the lane saturates at both ends.
          if (up_now && !dn_now && lane_q != 2'd0)      lane_d = lane_q - 2'd1;
          else if (dn_now && !up_now && lane_q != 2'd2) lane_d = lane_q + 2'd1;
          up_pend_d = 1'b0;
          dn_pend_d = 1'b0;
        end
      end
      ST_LOAD:  state_d = ST_TREE;
      ST_TREE:  if (draw_tree_finish) state_d = ST_MAN;
      ST_MAN:   if (draw_man_finish) state_d = ST_CHECK;
      ST_CHECK: begin
        if (collide) begin
          state_d    = ST_OVER;
          over_cnt_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OVER: begin
        if (over_cnt_q == OC_LAST) state_d = ST_DEAD;
        else                       over_cnt_d = over_cnt_q + 1'b1;
      end
      ST_DEAD: begin
        // Restart the game without redrawing the floors.
        if (start_edge) begin
          state_d      = ST_ERASE;
          tree_x_d     = X_START;
          lane_d       = 2'd2;
          man_style_d  = 1'b1;
          score_d      = 8'd0;
          top_d        = SHAPE_TOPGAP;
          mid_d        = SHAPE_BOTGAP;
          bot_d        = SHAPE_WALL;
          up_pend_d    = 1'b0;
          dn_pend_d    = 1'b0;
          consume_tick = 1'b1;
        end
      end
      default: state_d = ST_FLOORS;
    endcase

    // Pending flag is sticky: several ticks during one frame collapse.
    tick_pend_d = (tick_pend_q & ~consume_tick) | (tick & ticks_enabled);

    y_in_d           = lane_to_y(lane_d);
    drawing_floors_d = (state_d == ST_FLOORS);
    erase_d          = (state_d == ST_ERASE);
    draw_tree_d      = (state_d == ST_TREE);
    draw_man_d       = (state_d == ST_MAN);
    gameover_d       = (state_d == ST_OVER);
    ld_frame_d       = (state_d == ST_LOAD);
    plot_d           = drawing_floors_d | erase_d | draw_tree_d | draw_man_d | gameover_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_FLOORS;
      frame_cnt_q      <= '0;
      over_cnt_q       <= '0;
      tick_pend_q      <= 1'b0;
      up_prev_q        <= 1'b0;
      dn_prev_q        <= 1'b0;
      start_prev_q     <= 1'b0;
      up_pend_q        <= 1'b0;
      dn_pend_q        <= 1'b0;
      tree_x_q         <= X_START;
      lane_q           <= 2'd2;
      y_in_q           <= LANE2_Y;
      man_style_q      <= 1'b1;
      score_q          <= 8'd0;
      top_q            <= SHAPE_TOPGAP;
      mid_q            <= SHAPE_BOTGAP;
      bot_q            <= SHAPE_WALL;
      drawing_floors_q <= 1'b0;
      erase_q          <= 1'b0;
      draw_tree_q      <= 1'b0;
      draw_man_q       <= 1'b0;
      gameover_q       <= 1'b0;
      plot_q           <= 1'b0;
      ld_frame_q       <= 1'b0;
      ld_shape_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      over_cnt_q       <= over_cnt_d;
      tick_pend_q      <= tick_pend_d;
      up_prev_q        <= key_up;
      dn_prev_q        <= key_down;
      start_prev_q     <= key_start;
      up_pend_q        <= up_pend_d;
      dn_pend_q        <= dn_pend_d;
      tree_x_q         <= tree_x_d;
      lane_q           <= lane_d;
      y_in_q           <= y_in_d;
      man_style_q      <= man_style_d;
      score_q          <= score_d;
      top_q            <= top_d;
      mid_q            <= mid_d;
      bot_q            <= bot_d;
      drawing_floors_q <= drawing_floors_d;
      erase_q          <= erase_d;
      draw_tree_q      <= draw_tree_d;
      draw_man_q       <= draw_man_d;
      gameover_q       <= gameover_d;
      plot_q           <= plot_d;
      ld_frame_q       <= ld_frame_d;
      ld_shape_q       <= ld_shape_d;
    end
  end

  assign drawing_floors = drawing_floors_q;
  assign erase          = erase_q;
  assign draw_tree      = draw_tree_q;
  assign draw_man       = draw_man_q;
  assign gameover       = gameover_q;
  assign plot           = plot_q;
  assign ld_x           = ld_frame_q;
  assign ld_y           = ld_frame_q;
  assign ld_man_style   = ld_frame_q;
  assign ld_shape       = ld_shape_q;
  assign x_in           = tree_x_q;
  assign y_in           = y_in_q;
  assign man_style      = man_style_q;
  assign top            = top_q;
  assign mid            = mid_q;
  assign bottom         = bot_q;
  assign score          = score_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_runner_frame_ctrl.sv
// Testbench for runner_frame_ctrl: randomized key stimulus per frame, a
// game-level reference model producing one expected LOAD record per frame,
// and a monitor that pops and compares on every LOAD strobe.
`timescale 1ns/1ps
module tb_runner_frame_ctrl;
  import runner_pkg::*;

  localparam int FRAME_DIV   = 50;
  localparam int OVER_CYCLES = 160 * 120;
  localparam int TREE_X      = 156;
  localparam int EXP_W       = 26;

  logic clk = 1'b0;
  logic reset_n;
  logic key_up, key_down, key_crouch, key_start;
  logic draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish;
  logic drawing_floors, erase, draw_tree, draw_man, gameover;
  logic ld_x, ld_y, ld_man_style, ld_shape;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic man_style;
  logic [1:0] top, mid, bottom;
  logic plot;
  logic [7:0] score;
  state_t dbg_state;

  runner_frame_ctrl #(.FRAME_DIV(FRAME_DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_up(key_up), .key_down(key_down), .key_crouch(key_crouch), .key_start(key_start),
    .draw_floors_finish(draw_floors_finish), .erase_finish(erase_finish),
    .draw_tree_finish(draw_tree_finish), .draw_man_finish(draw_man_finish),
    .drawing_floors(drawing_floors), .erase(erase), .draw_tree(draw_tree),
    .draw_man(draw_man), .gameover(gameover),
    .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style), .ld_shape(ld_shape),
    .x_in(x_in), .y_in(y_in), .man_style(man_style),
    .top(top), .mid(mid), .bottom(bottom),
    .plot(plot), .score(score), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic settled;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) settled <= 1'b0;
    else          settled <= 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and compare ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- datapath responder ----------------
  // Each draw phase reports finish (as a level) three cycles after it starts.
  logic [3:0] prev_sel = 4'b0;
  int phase_cnt = 0;
  always @(negedge clk) begin
    logic [3:0] sel;
    sel = {drawing_floors, erase, draw_tree, draw_man};
    if (sel != prev_sel) phase_cnt = 0;
    else                 phase_cnt++;
    prev_sel = sel;
    {draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish} =
      (phase_cnt >= 2) ? sel : 4'b0;
  end

  // ---------------- reference model ----------------
  int m_x, m_lane, m_score, m_wraps;
  bit m_style, m_collide;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [6:0] model_y(input int lane);
    if (lane == 0)      return 7'd28;
    else if (lane == 1) return 7'd68;
    else                return 7'd108;
  endfunction

  task automatic model_reset();
    m_x = TREE_X; m_lane = 2; m_score = 0; m_style = 1'b1; m_collide = 1'b0;
  endtask

  // One frame of game rules; pushes the record the next LOAD must show.
  task automatic model_frame(input bit up, input bit dn, input bit crouch);
    int step;
    bit wrap, ovl;
    logic [1:0] shp;
    step = 1;
`ifdef SPEEDUP_EN
    if (m_score >= 16)     step = 3;
    else if (m_score >= 8) step = 2;
`endif
    wrap = (m_x < step);
    if (wrap) begin
      m_x = TREE_X;
      if (m_score < 255) m_score++;
      m_wraps++;
    end else begin
      m_x = m_x - step;
    end
    if (up && !dn && m_lane > 0)      m_lane--;
    else if (dn && !up && m_lane < 2) m_lane++;
    m_style = !crouch;
    shp = (m_lane == 0) ? top : (m_lane == 1) ? mid : bottom;
    ovl = (m_x + 1 >= 25) && (m_x <= 31);
    m_collide = !wrap && ovl && !(shp == 2'b10 && m_style == 1'b0);
    exp_q.push_back({8'(m_x), model_y(m_lane), m_style, wrap, 8'(m_score), m_collide});
  endtask

  // ---------------- monitor ----------------
  state_t prev_state = ST_FLOORS;
  bit pend_collide = 1'b0;
  int shape_pulses = 0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [4:0] exp_sel, act_sel;
    bit exp_ld;
    if (!reset_n) begin
      prev_state = ST_FLOORS;
    end else begin
      if (settled) begin
        exp_sel = {dbg_state == ST_FLOORS, dbg_state == ST_ERASE, dbg_state == ST_TREE,
                   dbg_state == ST_MAN, dbg_state == ST_OVER};
        act_sel = {drawing_floors, erase, draw_tree, draw_man, gameover};
        exp_ld  = (dbg_state == ST_LOAD);
        check("phase_outputs",
              {act_sel, plot, ld_x, ld_y, ld_man_style, ld_shape & ~exp_ld},
              {exp_sel, |exp_sel, exp_ld, exp_ld, exp_ld, 1'b0});
      end
      if (ld_x) begin
        check("load_has_expectation", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("x_in", x_in, e[25:18]);
          check("y_in", y_in, e[17:11]);
          check("man_style", man_style, e[10]);
          check("ld_shape", ld_shape, e[9]);
          check("score", score, e[8:1]);
          pend_collide = e[0];
        end
        if (ld_shape) begin
          shape_pulses++;
          check("passable_lane", (top == 2'b10) || (mid == 2'b10) || (bottom == 2'b10), 1);
        end
      end
      if (prev_state == ST_CHECK) check("check_exit_over", dbg_state == ST_OVER, pend_collide);
      prev_state = dbg_state;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input state_t st, input int max_cyc, input string name);
    int n = 0;
    while (dbg_state != st && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, dbg_state == st, 1);
  endtask

  task automatic run_frame(input bit up, input bit dn, input bit crouch);
    int n = 0;
    wait_state(ST_WAIT, 400, "reach_wait");
    key_crouch = crouch;
    key_up     = up;
    key_down   = dn;
    model_frame(up, dn, crouch);
    @(negedge clk);
    key_up   = 1'b0;
    key_down = 1'b0;
    while (dbg_state == ST_WAIT && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Random keys, but steer to a bottom-gap lane and crouch near the man.
  task automatic random_frame();
    bit up, dn, cr;
    int target;
    if (m_x >= 20 && m_x <= 60) begin
      target = (top == 2'b10) ? 0 : (mid == 2'b10) ? 1 : 2;
      up = (m_lane > target);
      dn = (m_lane < target);
      cr = 1'b1;
    end else begin
      up = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 3) == 0);
      cr = 1'($urandom_range(0, 1));
    end
    run_frame(up, dn, cr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    state_t seq[$];
    state_t exp_seq[8];
    int n;
    exp_seq = '{ST_FLOORS, ST_WAIT, ST_ERASE, ST_LOAD, ST_TREE, ST_MAN, ST_CHECK, ST_WAIT};
    reset_n = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_crouch = 1'b0; key_start = 1'b0;
    m_wraps = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_selects", {drawing_floors, erase, draw_tree, draw_man, gameover, plot}, 0);
    check("rst_strobes", {ld_x, ld_y, ld_man_style, ld_shape}, 0);
    check("rst_score", score, 0);
    check("rst_x_in", x_in, TREE_X);
    check("rst_y_in", y_in, 108);
    check("rst_man_style", man_style, 1);
    check("rst_shapes", {top, mid, bottom}, 6'b00_10_11);
    check("rst_state", dbg_state, ST_FLOORS);

    // First frame: no keys, standing.
    model_frame(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    seq.push_back(dbg_state);
    n = 0;
    while (seq.size() < 8 && n < 300) begin
      @(negedge clk);
      n++;
      if (dbg_state != seq[$]) seq.push_back(dbg_state);
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("seq_%0d", i), (i < seq.size()) ? int'(seq[i]) : -1, int'(exp_seq[i]));

    // Directed lane moves: up, up, up (saturate), up+down (cancel), down.
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1);

    // Random frames through the first obstacle wrap.
    for (int f = 0; f < 160; f++) random_frame();

    // Stand in lane 2 until the obstacle hits.
    n = 0;
    while (!m_collide && n < 250) begin
      run_frame(1'b0, 1'b1, 1'b0);
      n++;
    end
    check("collision_reached", m_collide, 1);
    wait_state(ST_OVER, 100, "reach_over");
    n = 0;
    while (gameover && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("gameover_cycles", n, OVER_CYCLES);
    check("dead_after_over", dbg_state, ST_DEAD);
    repeat (3 * FRAME_DIV) @(negedge clk);
    check("dead_ignores_ticks", dbg_state, ST_DEAD);
    check("dead_score", score, m_score);

    // Restart.
    model_reset();
    key_crouch = 1'b0;
    model_frame(1'b0, 1'b0, 1'b0);
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    check("restart_erase", dbg_state, ST_ERASE);
    check("restart_score", score, 0);
    check("restart_x", x_in, TREE_X);
    for (int f = 0; f < 6; f++) random_frame();

    // Asynchronous reset in the middle of TREE.
    wait_state(ST_TREE, 400, "reach_tree");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_selects", {drawing_floors, erase, draw_tree, draw_man, gameover, plot}, 0);
    check("async_rst_strobes", {ld_x, ld_y, ld_man_style, ld_shape}, 0);
    check("async_rst_state", dbg_state, ST_FLOORS);
    check("async_rst_score", score, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", dbg_state, ST_FLOORS);
    check("post_rst_floors", drawing_floors, 1);

    check("exp_queue_drained", exp_q.size(), 0);
    check("shape_pulse_count", shape_pulses, m_wraps);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/runner_frame_ctrl.md
Name: runner_frame_ctrl

Overview:
- Control FSM for the running-man drawing datapath: draws the floors once after reset, then runs a once-per-frame erase -> load -> tree -> man -> check sequence.
- Owns game state: obstacle x position, man lane and posture, obstacle shapes, score and collision.
- Drives the datapath's draw/load strobes and the VGA adapter write enable.

Parameters:
- FRAME_DIV, 833333: clk cycles per frame tick (60 Hz at 50 MHz).
- TREE_X_START, 156: obstacle x loaded at start and on wrap.
- MAN_X, 25: fixed man left column; the man is 7 px wide.
- OVER_CYCLES, 19200: cycles spent in the game-over fill (160*120).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- key_up, key_down, key_crouch, key_start  in  1  synchronous level inputs from debounced keys
- draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish  in  1  datapath done levels
- drawing_floors, erase, draw_tree, draw_man, gameover  out  1  datapath phase selects
- ld_x, ld_y, ld_man_style, ld_shape  out  1  datapath load strobes, one cycle wide
- x_in  out  8  obstacle x
- y_in  out  7  man top row
- man_style  out  1  1=normal, 0=crouch
- top, mid, bottom  out  2 each  lane shapes: 00/01 top gap, 10 bottom gap, 11 wall
- plot  out  1  VGA write enable
- score  out  8  obstacles passed, saturating at 255

Behaviour:
- Reset values: all strobes and phase selects 0; plot=0; score=0; tree_x=TREE_X_START; lane=2 (y 108); man_style=1; shapes {00,10,11}; state FLOORS.
- Lane-to-y mapping: lane 0=28, lane 1=68, lane 2=108.
- States and transitions:
  - FLOORS: drawing_floors=1, plot=1; on draw_floors_finish -> WAIT.
  - WAIT: outputs idle; on pending frame tick -> ERASE and clear the pending flag.
  - ERASE: erase=1, plot=1; on erase_finish -> LOAD.
  - LOAD: exactly 1 cycle. ld_x, ld_y and ld_man_style are asserted. x_in and y_in carry the updated values. ld_shape is asserted only on the wrap cycle. -> TREE.
  - TREE: draw_tree=1, plot=1; on draw_tree_finish -> MAN.
  - MAN: draw_man=1, plot=1; on draw_man_finish -> CHECK.
  - CHECK: 1 cycle; -> OVER on collision, else -> WAIT.
  - OVER: gameover=1, plot=1 for OVER_CYCLES cycles -> DEAD.
  - DEAD: outputs idle; on a key_start rising edge, reset game state (not floors) -> ERASE.
- Frame tick: a free-running counter from 0 to FRAME_DIV-1 sets a sticky pending flag. Multiple ticks during a draw collapse into one. Ticks are ignored in OVER and DEAD.
- Obstacle update in LOAD:
  - If tree_x == 0, then tree_x <= TREE_X_START, new shapes come from the LFSR, and score increments. Otherwise tree_x <= tree_x - 1.
  - A score increment at 255 holds at 255.
- Keys:
  - key_up and key_down are rising-edge detected and latched as pending requests, consumed in LOAD.
  - Both pending at once: neither is applied; both are cleared.
  - Lane saturates at 0 (up) and 2 (down); there is no wrap.
  - man_style = !key_crouch, sampled in LOAD.
- Collision, evaluated in CHECK:
  - Overlap: tree_x+1 >= MAN_X and tree_x <= MAN_X+6, using 9-bit compares.
  - Safe only if the current lane's shape == 10 and man_style == 0. Any other overlap is a collision.
- Datapath finish flags are treated as levels. The controller never asserts two phase selects at once.
- Asynchronous reset mid-operation, including in OVER, returns to FLOORS within one cycle.

Optional Feature:
- SPEEDUP_EN defined: tree_x steps by 2 once score >= 8 and by 3 once score >= 16. Wrap occurs when tree_x < step, so the wrap cycle never underflows.
- Without SPEEDUP_EN: step is fixed at 1.

Decomposition:
- Package runner_pkg holds:
  - the state enum;
  - lane y constants (28, 68, 108);
  - shape codes SHAPE_TOPGAP=2'b00, SHAPE_BOTGAP=2'b10, SHAPE_WALL=2'b11;
  - screen limits 160/120.
- One sub-module, shape_lfsr:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5;
  - advances on ld_shape and outputs three 2-bit shapes;
  - at least one lane is forced to SHAPE_BOTGAP so every obstacle is passable.

Test Plan:
- Reset, FRAME_DIV=50, finish levels asserted after 3 cycles -> sequence FLOORS, WAIT, ERASE, LOAD, TREE, MAN, CHECK, WAIT; x_in=155 on the first LOAD; plot high only in draw states.
- 157 frames with no collision (man lane 2 crouched, bottom shape forced to 10) -> wrap gives x_in=156, ld_shape pulses once, score=1.
- key_up pulse twice then a third time -> y_in 68, 28, 28; simultaneous up+down -> y_in unchanged.
- Lane 2 standing (man_style=1) when tree_x reaches 31 -> CHECK goes to OVER; gameover high exactly 19200 cycles; DEAD; key_start -> ERASE with score=0 and tree_x=156.
- Reset asserted mid-TREE -> all outputs 0 asynchronously; after release, state FLOORS with drawing_floors=1.
- SPEEDUP_EN with score preset to 8 -> successive x_in values decrease by 2; wrap from x=1 goes to 156 without underflow.
